// File: rtl/floating_point_pkg.sv
// ---------------------------------------------------------------------------
// floating_point_pkg
// Shared definitions for the FPU datapath: significand/product widths, the
// multiplier FSM state encoding and the iteration counter reload value.
// Also used by the FPU control unit and the rounder.
// ---------------------------------------------------------------------------
package floating_point_pkg;

  localparam int MANT_WIDTH = 24;
  localparam int PROD_WIDTH = 2 * MANT_WIDTH;
  localparam int FRAC_WIDTH = MANT_WIDTH - 1;

  // The counter has to hold MANT_WIDTH (24), so 5 bits.
  localparam int                  CNT_WIDTH = 5;
  localparam logic [CNT_WIDTH-1:0] CNT_RESET = 5'd24;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = 5'd1;

  // Encoding 2'b11 is deliberately left unused; the FSM treats it as an
  // illegal state and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } mult_state_e;

endpackage

// File: rtl/floating_point_product_normalizer.sv
// ---------------------------------------------------------------------------
// floating_point_product_normalizer
// Purely combinational normalization of an unsigned significand product.
// The product of two [1,2) significands lies in [1,4), so it is either
// already normalized at bit PROD_WIDTH-2 or needs a one-bit right shift
// (signalled to the exponent adder through expIncrement_o).
//
// Ports:
//   product_i      in  PROD_WIDTH  raw unsigned product
//   mantissa_o     out FRAC_WIDTH  normalized fraction, hidden bit dropped
//   guard_o        out 1           first bit below the fraction
//   sticky_o       out 1           OR of all bits below the guard bit
//   expIncrement_o out 1           product MSB set, exponent needs +1
// ---------------------------------------------------------------------------
module floating_point_product_normalizer #(
  parameter int PROD_WIDTH = floating_point_pkg::PROD_WIDTH,
  parameter int FRAC_WIDTH = floating_point_pkg::FRAC_WIDTH
) (
  input  logic [PROD_WIDTH-1:0] product_i,
  output logic [FRAC_WIDTH-1:0] mantissa_o,
  output logic                  guard_o,
  output logic                  sticky_o,
  output logic                  expIncrement_o
);

  // Bit positions for the two alignments: "Hi" when the MSB is set, "Lo"
  // when the leading one sits one position lower.
  localparam int FracTopHi  = PROD_WIDTH - 2;
  localparam int GuardHi    = PROD_WIDTH - 2 - FRAC_WIDTH;
  localparam int StickyTopHi = GuardHi - 1;
  localparam int FracTopLo  = PROD_WIDTH - 3;
  localparam int GuardLo    = PROD_WIDTH - 3 - FRAC_WIDTH;
  localparam int StickyTopLo = GuardLo - 1;

  always_comb begin
    expIncrement_o = product_i[PROD_WIDTH-1];
    if (product_i[PROD_WIDTH-1]) begin
      mantissa_o = product_i[FracTopHi -: FRAC_WIDTH];
      guard_o    = product_i[GuardHi];
      sticky_o   = |product_i[StickyTopHi:0];
    end else begin
      mantissa_o = product_i[FracTopLo -: FRAC_WIDTH];
      guard_o    = product_i[GuardLo];
      sticky_o   = |product_i[StickyTopLo:0];
    end
  end

endmodule

// File: rtl/floating_point_mantissa_multiplier.sv
// ---------------------------------------------------------------------------
// floating_point_mantissa_multiplier
// Sequential radix-2 shift-add multiplier for two 24-bit significands
// (hidden bit included). One partial product per cycle, then one cycle to
// register the normalized fraction, guard/sticky and exponent increment.
//
// Ports:
//   clk                in  1   rising-edge clock
//   reset              in  1   asynchronous active-high reset
//   start              in  1   request, only looked at while IDLE
//   mantissaA          in  24  multiplicand
//   mantissaB          in  24  multiplier
//   doneMultiplication out 1   result valid, held until next accept
//   busy               out 1   operation in progress
//   product            out 48  raw unsigned product
//   mantissaOut        out 23  normalized fraction
//   guardBit           out 1   guard bit for the rounder
//   stickyBit          out 1   sticky bit for the rounder
//   expIncrement       out 1   product MSB set, exponent needs +1
//   zeroResult         out 1   an operand was zero
// ---------------------------------------------------------------------------
module floating_point_mantissa_multiplier #(
  parameter int MANT_WIDTH = floating_point_pkg::MANT_WIDTH,
  parameter int PROD_WIDTH = floating_point_pkg::PROD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MANT_WIDTH-1:0] mantissaA,
  input  logic [MANT_WIDTH-1:0] mantissaB,
  output logic                  doneMultiplication,
  output logic                  busy,
  output logic [PROD_WIDTH-1:0] product,
  output logic [MANT_WIDTH-2:0] mantissaOut,
  output logic                  guardBit,
  output logic                  stickyBit,
  output logic                  expIncrement,
  output logic                  zeroResult
);

  import floating_point_pkg::*;

  localparam int FracW = MANT_WIDTH - 1;

  mult_state_e            stateQ, stateD;
  logic [PROD_WIDTH-1:0]  multiplicandQ, multiplicandD;
  logic [MANT_WIDTH-1:0]  multiplierQ, multiplierD;
  logic [PROD_WIDTH-1:0]  accQ, accD;
  logic [CNT_WIDTH-1:0]   counterQ, counterD;

  logic                   doneQ, doneD;
  logic                   busyQ, busyD;
  logic [PROD_WIDTH-1:0]  productQ, productD;
  logic [FracW-1:0]       mantQ, mantD;
  logic                   guardQ, guardD;
  logic                   stickyQ, stickyD;
  logic                   expIncQ, expIncD;
  logic                   zeroQ, zeroD;

  logic [FracW-1:0]       normMant;
  logic                   normGuard;
  logic                   normSticky;
  logic                   normExpInc;

  // The normalizer always looks at the accumulator; its outputs are only
  // captured in FINISH, when the accumulator holds the complete product.
  floating_point_product_normalizer #(
    .PROD_WIDTH (PROD_WIDTH),
    .FRAC_WIDTH (FracW)
  ) uNormalizer (
    .product_i      (accQ),
    .mantissa_o     (normMant),
    .guard_o        (normGuard),
    .sticky_o       (normSticky),
    .expIncrement_o (normExpInc)
  );

  // Next-state logic. Result registers hold by default so the previous
  // result stays visible until a new one is written in FINISH; only
  // zeroResult and the handshake flags change at accept.
  always_comb begin
    stateD        = stateQ;
    multiplicandD = multiplicandQ;
    multiplierD   = multiplierQ;
    accD          = accQ;
    counterD      = counterQ;
    doneD         = doneQ;
    busyD         = busyQ;
    productD      = productQ;
    mantD         = mantQ;
    guardD        = guardQ;
    stickyD       = stickyQ;
    expIncD       = expIncQ;
    zeroD         = zeroQ;

    case (stateQ)
      IDLE: begin
        if (start) begin
          multiplicandD = {{(PROD_WIDTH-MANT_WIDTH){1'b0}}, mantissaA};
          multiplierD   = mantissaB;
          accD          = '0;
          counterD      = CNT_RESET;
          busyD         = 1'b1;
          doneD         = 1'b0;
          // A zero operand skips the iterations: the cleared accumulator
          // already is the product.
          if ((mantissaA == '0) || (mantissaB == '0)) begin
            zeroD  = 1'b1;
            stateD = FINISH;
          end else begin
            zeroD  = 1'b0;
            stateD = RUN;
          end
        end
      end

      RUN: begin
        if (multiplierQ[0]) begin
          accD = accQ + multiplicandQ;
        end
        multiplicandD = multiplicandQ << 1;
        multiplierD   = multiplierQ >> 1;
        counterD      = counterQ - CNT_ONE;
        if (counterQ == CNT_ONE) begin
          stateD = FINISH;
        end
      end

      FINISH: begin
        productD = accQ;
        mantD    = normMant;
        guardD   = normGuard;
        stickyD  = normSticky;
        expIncD  = normExpInc;
        doneD    = 1'b1;
        busyD    = 1'b0;
        stateD   = IDLE;
      end

      default: begin
        stateD   = IDLE;
        counterD = '0;
        doneD    = 1'b0;
        busyD    = 1'b0;
        productD = '0;
        mantD    = '0;
        guardD   = 1'b0;
        stickyD  = 1'b0;
        expIncD  = 1'b0;
        zeroD    = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ        <= IDLE;
      multiplicandQ <= '0;
      multiplierQ   <= '0;
      accQ          <= '0;
      counterQ      <= '0;
      doneQ         <= 1'b0;
      busyQ         <= 1'b0;
      productQ      <= '0;
      mantQ         <= '0;
      guardQ        <= 1'b0;
      stickyQ       <= 1'b0;
      expIncQ       <= 1'b0;
      zeroQ         <= 1'b0;
    end else begin
      stateQ        <= stateD;
      multiplicandQ <= multiplicandD;
      multiplierQ   <= multiplierD;
      accQ          <= accD;
      counterQ      <= counterD;
      doneQ         <= doneD;
      busyQ         <= busyD;
      productQ      <= productD;
      mantQ         <= mantD;
      guardQ        <= guardD;
      stickyQ       <= stickyD;
      expIncQ       <= expIncD;
      zeroQ         <= zeroD;
    end
  end

  assign doneMultiplication = doneQ;
  assign busy               = busyQ;
  assign product            = productQ;
  assign mantissaOut        = mantQ;
  assign guardBit           = guardQ;
  assign stickyBit          = stickyQ;
  assign expIncrement       = expIncQ;
  assign zeroResult         = zeroQ;

endmodule

// File: tb/tb_floating_point_mantissa_multiplier.sv
// ---------------------------------------------------------------------------
// tb_floating_point_mantissa_multiplier
// Directed vectors with hand-computed results. The stimulus process pushes
// the expected response when it issues a request; a monitor process pops
// and compares whenever doneMultiplication rises.
// ---------------------------------------------------------------------------
module tb_floating_point_mantissa_multiplier;

  typedef struct {
    logic [47:0] product;
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic        expInc;
    logic        zero;
    int          latency;
    int          acceptCycle;
  } expected_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] mantissaA;
  logic [23:0] mantissaB;
  logic        doneMultiplication;
  logic        busy;
  logic [47:0] product;
  logic [22:0] mantissaOut;
  logic        guardBit;
  logic        stickyBit;
  logic        expIncrement;
  logic        zeroResult;

  expected_t expQ[$];
  int        checkCount = 0;
  int        passCount  = 0;
  int        cycleCount = 0;

  floating_point_mantissa_multiplier dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .mantissaA          (mantissaA),
    .mantissaB          (mantissaB),
    .doneMultiplication (doneMultiplication),
    .busy               (busy),
    .product            (product),
    .mantissaOut        (mantissaOut),
    .guardBit           (guardBit),
    .stickyBit          (stickyBit),
    .expIncrement       (expIncrement),
    .zeroResult         (zeroResult)
  );

  // 10-unit clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle count advances on each rising edge, used for latency checks
  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison, counted
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one request at the next rising edge and record its expectation
  task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b,
                               input logic [47:0] prod, input logic [22:0] mant,
                               input logic g, input logic s, input logic e,
                               input logic z, input int lat);
    expected_t item;
    @(negedge clk);
    mantissaA = a;
    mantissaB = b;
    start     = 1'b1;
    item.product     = prod;
    item.mant        = mant;
    item.guard       = g;
    item.sticky      = s;
    item.expInc      = e;
    item.zero        = z;
    item.latency     = lat;
    item.acceptCycle = cycleCount + 1;
    expQ.push_back(item);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy after accept", {63'd0, busy}, 64'd1);
    checkOutput("done after accept", {63'd0, doneMultiplication}, 64'd0);
  endtask

  // Bounded wait for the current operation to complete
  task automatic waitDone(input int limit);
    int n;
    n = 0;
    while (!(doneMultiplication && !busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!(doneMultiplication && !busy)) begin
      checkOutput("wait for done timeout", 64'd0, 64'd1);
    end
  endtask

  // Monitor: compares each new result against the head of the scoreboard
  initial begin
    logic      prevDone;
    expected_t item;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (doneMultiplication && !prevDone) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected result", 64'd1, 64'd0);
        end else begin
          item = expQ.pop_front();
          checkOutput("product",      {16'd0, product},           {16'd0, item.product});
          checkOutput("mantissaOut",  {41'd0, mantissaOut},       {41'd0, item.mant});
          checkOutput("guardBit",     {63'd0, guardBit},          {63'd0, item.guard});
          checkOutput("stickyBit",    {63'd0, stickyBit},         {63'd0, item.sticky});
          checkOutput("expIncrement", {63'd0, expIncrement},      {63'd0, item.expInc});
          checkOutput("zeroResult",   {63'd0, zeroResult},        {63'd0, item.zero});
          checkOutput("busy at done", {63'd0, busy},              64'd0);
          checkOutput("latency",      64'(cycleCount - item.acceptCycle),
                                      64'(item.latency));
        end
      end
      prevDone = doneMultiplication;
    end
  end

  initial begin
    int        acc1;
    expected_t item;
    reset     = 1'b1;
    start     = 1'b0;
    mantissaA = '0;
    mantissaB = '0;
    #1;
    checkOutput("reset done",    {63'd0, doneMultiplication}, 64'd0);
    checkOutput("reset busy",    {63'd0, busy},               64'd0);
    checkOutput("reset product", {16'd0, product},            64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1.0 x 1.0
    applyStimulus(24'h800000, 24'h800000, 48'h400000000000, 23'h000000, 0, 0, 0, 0, 25);
    waitDone(40);
    // 1.5 x 1.5, product needs the exponent increment
    applyStimulus(24'hC00000, 24'hC00000, 48'h900000000000, 23'h100000, 0, 0, 1, 0, 25);
    waitDone(40);
    // Largest significands: sticky set
    applyStimulus(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 23'h7FFFFE, 0, 1, 1, 0, 25);
    waitDone(40);
    // LSB of the fraction set, no increment
    applyStimulus(24'h800001, 24'h800000, 48'h400000800000, 23'h000001, 0, 0, 0, 0, 25);
    waitDone(40);
    // Guard bit set, no increment
    applyStimulus(24'hC00000, 24'h800001, 48'h600000C00000, 23'h400001, 1, 0, 0, 0, 25);
    waitDone(40);
    // Zero operands take the one-cycle path
    applyStimulus(24'h000000, 24'hABCDEF, 48'h0, 23'h0, 0, 0, 0, 1, 1);
    waitDone(40);
    applyStimulus(24'h123456, 24'h000000, 48'h0, 23'h0, 0, 0, 0, 1, 1);
    waitDone(40);

    // Start pulsed mid-run is ignored; only the original result appears
    applyStimulus(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 23'h7FFFFE, 0, 1, 1, 0, 25);
    repeat (4) @(negedge clk);
    mantissaA = 24'h800000;
    mantissaB = 24'h800000;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(40);
    repeat (3) @(negedge clk);
    checkOutput("no extra result queue", 64'(expQ.size()), 64'd0);
    checkOutput("product after ignored start", {16'd0, product}, 64'h0000FFFFFE000001);

    // Reset in the middle of a run clears everything at once
    applyStimulus(24'h800000, 24'h800000, 48'h400000000000, 23'h000000, 0, 0, 0, 0, 25);
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrun reset done",     {63'd0, doneMultiplication}, 64'd0);
    checkOutput("midrun reset busy",     {63'd0, busy},               64'd0);
    checkOutput("midrun reset product",  {16'd0, product},            64'd0);
    checkOutput("midrun reset mantissa", {41'd0, mantissaOut},        64'd0);
    checkOutput("midrun reset sticky",   {63'd0, stickyBit},          64'd0);
    checkOutput("midrun reset expInc",   {63'd0, expIncrement},       64'd0);
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("no done after reset", {63'd0, doneMultiplication}, 64'd0);

    // Fresh 1.0 x 1.0 after reset
    applyStimulus(24'h800000, 24'h800000, 48'h400000000000, 23'h000000, 0, 0, 0, 0, 25);
    waitDone(40);

    // Back-to-back with start held high
    @(negedge clk);
    mantissaA = 24'hC00000;
    mantissaB = 24'hC00000;
    start     = 1'b1;
    acc1      = cycleCount + 1;
    item = '{48'h900000000000, 23'h100000, 1'b0, 1'b0, 1'b1, 1'b0, 25, acc1};
    expQ.push_back(item);
    item = '{48'hFFFFFE000001, 23'h7FFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 25, acc1 + 26};
    expQ.push_back(item);
    @(negedge clk);
    mantissaA = 24'hFFFFFF;
    mantissaB = 24'hFFFFFF;
    waitDone(40);
    @(negedge clk);
    checkOutput("b2b done one cycle", {63'd0, doneMultiplication}, 64'd0);
    checkOutput("b2b busy again",     {63'd0, busy},               64'd1);
    start = 1'b0;
    waitDone(40);
    repeat (2) @(negedge clk);
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
